// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver with active-low anode/segment outputs.
// Optional anti-ghosting blanking at the start of each slot: define SCAN_BLANK_EN.
module display_scan_driver #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_ddp,
    output logic [2:0] scan_idx
);

    localparam int DIV   = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       dec_q, dec_d;
    logic [2:0]       sidx_q;
    logic [5:0]       word_sel;
    logic             blank;

    // Active-low {a,b,c,d,e,f,g}; every hex value gets a distinct glyph.
    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
        word_sel = d1;
        case (idx_q)
            3'd0: word_sel = d1;
            3'd1: word_sel = d2;
            3'd2: word_sel = d3;
            3'd3: word_sel = d4;
            3'd4: word_sel = d5;
            3'd5: word_sel = d6;
            3'd6: word_sel = d7;
            3'd7: word_sel = d8;
            default: word_sel = d1;
        endcase
    end

`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    assign blank = (cnt_q < BLANK_LIM);
`else
    assign blank = 1'b0;
`endif

    // Input words are read live, so an edit to the active digit shows on the next clock.
    always_comb begin
        an_d  = 8'hFF;
        dec_d = 8'hFF;
        if (!blank && word_sel[5]) begin
            an_d  = ~(8'b1 << idx_q);
            dec_d = {seg7(word_sel[4:1]), word_sel[0]};
        end
    end

    // ---- output register stage: one clock behind idx/cnt and the inputs ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            an_q   <= 8'hFF;
            dec_q  <= 8'hFF;
            sidx_q <= 3'd0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            dec_q  <= dec_d;
            sidx_q <= idx_q;
        end
    end

    assign an       = an_q;
    assign dec_ddp  = dec_q;
    assign scan_idx = sidx_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver at DIV=4: vector table, hand corner sequences, random run vs model.
module tb_display_scan_driver;

    localparam int CLK_HZ = 100;
    localparam int SCAN   = 25;
    localparam int DIV    = CLK_HZ / SCAN;
    localparam int BLANK  = 1;
`ifdef SCAN_BLANK_EN
    localparam int BLK = BLANK;
`else
    localparam int BLK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] w [8];
    logic [7:0] an, dec_ddp;
    logic [2:0] scan_idx;

    int checks = 0;
    int errors = 0;
    logic [6:0] seg_tab [16];

    typedef struct {
        int         slot;
        logic [5:0] word;
        logic [7:0] an;
        logic [7:0] dec;
    } vec_t;
    vec_t tv [8];

    display_scan_driver #(
        .CLK_FREQ_HZ (CLK_HZ),
        .SCAN_HZ     (SCAN),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .d1      (w[0]),
        .d2      (w[1]),
        .d3      (w[2]),
        .d4      (w[3]),
        .d5      (w[4]),
        .d6      (w[5]),
        .d7      (w[6]),
        .d8      (w[7]),
        .an      (an),
        .dec_ddp (dec_ddp),
        .scan_idx(scan_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_onehot();
        int lows;
        lows = 0;
        for (int k = 0; k < 8; k++) if (an[k] === 1'b0) lows++;
        chk("one_anode", 8'(lows <= 1), 8'd1);
    endtask

    // Expected outputs visible after the e-th rising edge since reset release.
    task automatic model(input int e, output logic [7:0] e_an, output logic [7:0] e_dec,
                         output logic [7:0] e_idx);
        int slot, c;
        slot  = ((e - 1) / DIV) % 8;
        c     = (e - 1) % DIV;
        e_idx = 8'(slot);
        if (c < BLK || w[slot][5] == 1'b0) begin
            e_an  = 8'hFF;
            e_dec = 8'hFF;
        end else begin
            e_an  = 8'hFF ^ (8'h01 << slot);
            e_dec = {seg_tab[w[slot][4:1]], w[slot][0]};
        end
    endtask

    task automatic clear_words();
        for (int i = 0; i < 8; i++) w[i] = 6'b0_0000_1;
    endtask

    task automatic enable_all();
        for (int i = 0; i < 8; i++) w[i] = {1'b1, 4'(i + 3), 1'b1};
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_an", an, 8'hFF);
        chk("rst_dec", dec_ddp, 8'hFF);
        chk("rst_idx", {5'd0, scan_idx}, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rel_an", an, 8'hFF);
        chk("post_rel_dec", dec_ddp, 8'hFF);
    endtask

    task automatic check_edge(input string tag, input int e);
        logic [7:0] ea, ed, ei;
        model(e, ea, ed, ei);
        chk({tag, "_an"}, an, ea);
        chk({tag, "_dec"}, dec_ddp, ed);
        chk({tag, "_idx"}, {5'd0, scan_idx}, ei);
        chk_onehot();
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tv[0] = '{0, 6'b1_0101_1, 8'hFE, 8'b0100100_1};
        tv[1] = '{5, 6'b0_0000_1, 8'hFF, 8'hFF};
        tv[2] = '{1, 6'b1_1000_0, 8'hFD, 8'h00};
        tv[3] = '{1, 6'b1_1111_1, 8'hFD, 8'b0111000_1};
        tv[4] = '{2, 6'b1_0000_0, 8'hFB, 8'b0000001_0};
        tv[5] = '{3, 6'b1_0001_1, 8'hF7, 8'b1001111_1};
        tv[6] = '{7, 6'b1_1010_1, 8'h7F, 8'b0001000_1};
        tv[7] = '{6, 6'b1_1100_0, 8'hBF, 8'b0110001_0};
        clear_words();

        // Vector table: one lit (or dark) digit, checked in its slot.
        for (int t = 0; t < 8; t++) begin
            clear_words();
            w[tv[t].slot] = tv[t].word;
            do_reset();
            repeat (tv[t].slot * DIV + 1 + BLK) @(negedge clock);
            chk("vec_an", an, tv[t].an);
            chk("vec_dec", dec_ddp, tv[t].dec);
            chk("vec_idx", {5'd0, scan_idx}, 8'(tv[t].slot));
        end

        // Full walk with d6 dark, through one wrap of the frame.
        enable_all();
        w[5] = 6'b0_0000_1;
        do_reset();
        for (int e = 1; e <= 8 * DIV + 8; e++) begin
            @(negedge clock);
            check_edge("walk", e);
            if ((e - 1) / DIV == 5) begin
                chk("dark_an", an, 8'hFF);
                chk("dark_dec", dec_ddp, 8'hFF);
            end
        end

        // Live edit of the active digit shows on the next clock.
        clear_words();
        w[1] = 6'b1_1000_0;
        do_reset();
        repeat (DIV + 2) @(negedge clock);
        chk("live_before", dec_ddp, 8'h00);
        w[1] = 6'b1_1111_1;
        @(negedge clock);
        chk("live_after", dec_ddp, 8'b0111000_1);
        chk("live_an", an, 8'hFD);

        // Reset mid-slot 3: outputs blank at once, scan restarts at slot 0.
        enable_all();
        do_reset();
        repeat (3 * DIV + 2) @(negedge clock);
        chk("pre_rst_an", an, 8'hF7);
        reset = 1'b1;
        #1;
        chk("async_an", an, 8'hFF);
        chk("async_dec", dec_ddp, 8'hFF);
        chk("async_idx", {5'd0, scan_idx}, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (1 + BLK) @(negedge clock);
        chk("restart_an", an, 8'hFE);
        chk("restart_idx", {5'd0, scan_idx}, 8'd0);

        // Random words against the model.
        for (int i = 0; i < 8; i++) w[i] = 6'($urandom);
        do_reset();
        for (int e = 1; e <= 400; e++) begin
            @(negedge clock);
            check_edge("rand", e);
            if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 7)] = 6'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
